// File: rtl/risc16_pkg.sv
// risc16 shared constants for the fetch stage
// and its neighbours in the 16-bit datapath.
package risc16_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int PC_STEP    = 2;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  function automatic logic [3:0] opcode(
    input logic [INSTR_W-1:0] w
  );
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer between memory responses
// and decode; flush wins over push.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = count_q;

  // entry storage; the head is read straight from here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wr_q] <= wdata;
    end
  end

  // pointers and occupancy; pointers wrap since DEPTH is 2^n
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-limited issue to imem,
// prefetch buffering and redirect flush/discard.
module instr_fetch_unit
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       outstanding;
  logic              accept;
  logic              push;
  logic              pop;
  logic [FW-1:0]     head;
  logic [ADDR_W-1:0] target;

  // every issued or buffered fetch holds one slot
  assign outstanding = {1'b0, fifo_count}
                     + {1'b0, in_flight_q};

  assign imem_req_valid = ~reset & ~redirect
    & (outstanding < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign accept = imem_req_valid & imem_req_ready;
  assign push   = imem_rsp_valid & ~redirect
                & (discard_q == '0);
  assign pop    = instr_valid & instr_ready;
  assign target = redirect_pc & ~ADDR_W'(1);

  assign instr_valid     = ~fifo_empty;
  assign {instr, instr_pc} = head;

  fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({imem_rsp_data, rsp_pc_q}),
    .pop   (pop),
    .flush (redirect),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // next PC, in-flight and discard counts; redirect overrides
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    discard_d   = discard_q;
    in_flight_d = in_flight_q + CW'(accept)
                - CW'(imem_rsp_valid);
    if (accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + ADDR_W'(PC_STEP);
    end
    if (imem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      discard_d  = in_flight_d;
    end
  end

  // fetch state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  a_in_flight: assert property (
    @(posedge clk) disable iff (reset)
    in_flight_q <= CW'(DEPTH));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random + directed stimulus against
// a queue-based model of the fetch stage.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  int p_rdy, p_irdy, p_redir, lat_lo, lat_hi;
  bit force_redir, redir_on_pop_rsp, t6_hit;
  logic [15:0] redir_tgt;

  // memory environment: accepted addresses and due cycles
  logic [15:0] mq_addr[$];
  int          mq_due[$];

  // model: issue PC, in-flight fetches, buffered words
  logic [15:0] m_pc;
  logic [15:0] m_ifpc[$];
  bit          m_stale[$];
  logic [15:0] f_w[$];
  logic [15:0] f_pc[$];

  logic [15:0] acc_log[$];
  int          first_valid_cyc;
  bit          seen_v;
  logic [15:0] seen_pc;

  function automatic logic [15:0] memword(
    input logic [15:0] a
  );
    return {a[7:0] ^ 8'h5A, a[15:8]} + 16'h1357;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    mq_addr.delete();
    mq_due.delete();
    m_ifpc.delete();
    m_stale.delete();
    f_w.delete();
    f_pc.delete();
    acc_log.delete();
    m_pc = 16'h0000;
    first_valid_cyc = -1;
    force_redir = 1'b0;
    redir_on_pop_rsp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  task automatic step();
    bit          exp_rv, acc_m, pop_m, rsp, rd;
    bit          dut_acc, st;
    logic [15:0] tgt, dut_addr, a;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_rdy);
    instr_ready    = ($urandom_range(99) < p_irdy);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'($urandom);
    end
    rd = force_redir
      || ($urandom_range(99) < p_redir)
      || (redir_on_pop_rsp && imem_rsp_valid
          && instr_valid && instr_ready);
    if (rd && redir_on_pop_rsp) begin
      t6_hit = 1'b1;
      redir_on_pop_rsp = 1'b0;
    end
    tgt = force_redir ? redir_tgt : 16'($urandom);
    redirect    = rd;
    redirect_pc = tgt;
    #1;
    exp_rv = (f_w.size() + m_ifpc.size() < DEPTH) && !rd;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, f_w.size() > 0);
    if (f_w.size() > 0) begin
      chk("instr", instr, f_w[0]);
      chk("instr_pc", instr_pc, f_pc[0]);
    end
    if (instr_valid && first_valid_cyc < 0)
      first_valid_cyc = cyc;
    if (instr_valid && !seen_v) begin
      seen_v  = 1'b1;
      seen_pc = instr_pc;
    end
    acc_m    = exp_rv && imem_req_ready;
    pop_m    = (f_w.size() > 0) && instr_ready;
    rsp      = imem_rsp_valid;
    dut_acc  = imem_req_valid && imem_req_ready;
    dut_addr = imem_addr;
    @(posedge clk);
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (dut_acc) begin
      mq_addr.push_back(dut_addr);
      mq_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
      acc_log.push_back(dut_addr);
    end
    if (pop_m) begin
      void'(f_w.pop_front());
      void'(f_pc.pop_front());
    end
    if (rsp && m_ifpc.size() > 0) begin
      a  = m_ifpc.pop_front();
      st = m_stale.pop_front();
      if (!st && !rd) begin
        f_w.push_back(memword(a));
        f_pc.push_back(a);
      end
    end
    if (acc_m) begin
      m_ifpc.push_back(m_pc);
      m_stale.push_back(rd);
      m_pc = m_pc + 16'd2;
    end
    if (rd) begin
      foreach (m_stale[i]) m_stale[i] = 1'b1;
      f_w.delete();
      f_pc.delete();
      m_pc = tgt & 16'hFFFE;
    end
    cyc++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    t6_hit = 1'b0;
    seen_v = 1'b0;

    // 1: streaming, 1-cycle memory
    p_rdy = 100; p_irdy = 100; p_redir = 0;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (10) step();
    chk("t1_addr0", acc_log[0], 16'h0000);
    chk("t1_addr1", acc_log[1], 16'h0002);
    chk("t1_addr2", acc_log[2], 16'h0004);
    chk("t1_addr3", acc_log[3], 16'h0006);
    chk("t1_first_valid", first_valid_cyc, 2);

    // 2: decode stalled, credit limit
    p_irdy = 0;
    do_reset();
    repeat (8) step();
    #1;
    chk("t2_reqs", acc_log.size(), 4);
    chk("t2_last", acc_log[3], 16'h0006);
    chk("t2_valid_low", imem_req_valid, 1'b0);
    p_irdy = 100;
    step();
    p_irdy = 0;
    repeat (4) step();
    chk("t2_reqs_after_pop", acc_log.size(), 5);
    chk("t2_next_addr", acc_log[4], 16'h0008);

    // 3: memory stall holds request
    p_irdy = 0;
    do_reset();
    repeat (2) step();
    p_rdy = 0;
    repeat (5) begin
      step();
      #1;
      chk("t3_addr_hold", imem_addr, 16'h0004);
      chk("t3_valid_hold", imem_req_valid, 1'b1);
    end
    chk("t3_no_accept", acc_log.size(), 2);

    // 4: redirect with 3 fetches in flight
    p_rdy = 100; p_irdy = 100;
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (3) step();
    force_redir = 1'b1;
    redir_tgt = 16'h0041;
    step();
    force_redir = 1'b0;
    seen_v = 1'b0;
    seen_pc = 'x;
    repeat (12) step();
    chk("t4_first_pc", seen_pc, 16'h0040);
    chk("t4_new_addr", acc_log[3], 16'h0040);

    // 5: address wrap after redirect near top
    lat_lo = 1; lat_hi = 1;
    do_reset();
    force_redir = 1'b1;
    redir_tgt = 16'hFFFC;
    step();
    force_redir = 1'b0;
    acc_log.delete();
    repeat (6) step();
    chk("t5_a0", acc_log[0], 16'hFFFC);
    chk("t5_a1", acc_log[1], 16'hFFFE);
    chk("t5_a2", acc_log[2], 16'h0000);
    chk("t5_a3", acc_log[3], 16'h0002);

    // 6: redirect with pop and response together
    lat_lo = 2; lat_hi = 2;
    do_reset();
    t6_hit = 1'b0;
    redir_on_pop_rsp = 1'b1;
    for (int i = 0; i < 20 && !t6_hit; i++) step();
    chk("t6_triggered", t6_hit, 1'b1);
    #1;
    chk("t6_empty", instr_valid, 1'b0);
    redir_on_pop_rsp = 1'b0;
    repeat (6) step();

    // random traffic with a mid-run reset
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      p_rdy   = $urandom_range(100, 30);
      p_irdy  = $urandom_range(100, 20);
      p_redir = $urandom_range(8, 0);
      lat_lo  = 1;
      lat_hi  = $urandom_range(4, 1);
      repeat (250) step();
      if (seg == 3) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
